// File: rtl/rgb_led_arbiter.sv
`timescale 1ns/1ps
// Fixed-priority owner of the single active-low RGB LED with minimum visible hold and optional blink.
// req->grant/LED latency is one clk; grant, busy and LEDs all come straight from registers.
module rgb_led_arbiter #(
  parameter int CLK_HZ        = 12_000_000,
  parameter int NUM_REQ       = 4,
  parameter int MIN_HOLD_MS   = 100,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   color,
  input  logic [NUM_REQ-1:0]     blink,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   LED_R,
  output logic                   LED_G,
  output logic                   LED_B
);

  localparam int DIV    = CLK_HZ / 1000;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HOLD_W = (MIN_HOLD_MS > 0) ? $clog2(MIN_HOLD_MS + 1) : 1;
  localparam int PH_W   = $clog2(BLINK_HALF_MS + 1);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0]   PRE_ONE   = PRE_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(MIN_HOLD_MS);
  localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
  localparam logic [PH_W-1:0]    PH_INIT   = PH_W'(BLINK_HALF_MS);
  localparam logic [PH_W-1:0]    PH_ONE    = PH_W'(1);
  localparam logic [NUM_REQ-1:0] OH_ZERO   = NUM_REQ'(1);

  typedef enum logic {S_IDLE = 1'b0, S_SHOW = 1'b1} state_t;

  state_t               r_state;
  logic [PRE_W-1:0]     r_pre;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_busy;
  logic [2:0]           r_col;
  logic                 r_blk;
  logic [HOLD_W-1:0]    r_hold;
  logic                 r_phase;
  logic [PH_W-1:0]      r_phase_cnt;
  logic [2:0]           r_led;

  logic                 w_tick;
  logic                 w_any;
  logic [IDX_W-1:0]     w_win_idx;
  logic [NUM_REQ-1:0]   w_win;
  logic [2:0]           w_win_col;
  logic                 w_win_blk;
  logic                 w_load;
  logic                 w_release;

  function automatic logic [2:0] f_led(input logic on, input logic [2:0] col);
    return ~({3{on}} & col);
  endfunction

  assign w_tick = (r_pre == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_ONE;
    end
  end

  // Descending scan so the lowest requesting index is the last one written.
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_any     = 1'b1;
        w_win_idx = IDX_W'(i);
      end
    end
    w_win     = w_any ? (OH_ZERO << w_win_idx) : '0;
    w_win_col = color[3*w_win_idx +: 3];
    w_win_blk = blink[w_win_idx];
  end

  // In release phase the owner stays exactly when it is still the winner.
  always_comb begin
    w_load    = 1'b0;
    w_release = 1'b0;
    if (r_state == S_IDLE) begin
      w_load = w_any;
    end else if (r_hold == '0) begin
      w_load    = w_any && (w_win != r_grant);
      w_release = !w_any;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_col       <= '0;
      r_blk       <= 1'b0;
      r_hold      <= '0;
      r_phase     <= 1'b1;
      r_phase_cnt <= '0;
      r_led       <= 3'b111;
    end else if (w_load) begin
      r_state     <= S_SHOW;
      r_grant     <= w_win;
      r_busy      <= 1'b1;
      r_col       <= w_win_col;
      r_blk       <= w_win_blk;
      r_hold      <= HOLD_INIT;
      r_phase     <= 1'b1;
      r_phase_cnt <= PH_INIT;
      r_led       <= f_led(1'b1, w_win_col);
    end else if (w_release) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_led   <= 3'b111;
    end else if (r_state == S_SHOW && w_tick) begin
      if (r_hold != '0) begin
        r_hold <= r_hold - HOLD_ONE;
      end
      if (r_blk) begin
        if (r_phase_cnt <= PH_ONE) begin
          r_phase     <= ~r_phase;
          r_phase_cnt <= PH_INIT;
          r_led       <= f_led(~r_phase, r_col);
        end else begin
          r_phase_cnt <= r_phase_cnt - PH_ONE;
        end
      end
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign LED_R = r_led[2];
  assign LED_G = r_led[1];
  assign LED_B = r_led[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
`timescale 1ns/1ps
// Bench for rgb_led_arbiter: two instances (hold=3 ms and hold=0) driven by the same directed
// vectors, checked every cycle against a ticks-since-grant model plus literal expectations.
module tb_rgb_led_arbiter;

  localparam int NR   = 4;
  localparam int HZ   = 10_000;
  localparam int DIV  = HZ / 1000;
  localparam int HOLD = 3;
  localparam int BH   = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = '0;
  logic [11:0] color = '0;
  logic [3:0]  blink = '0;

  logic [3:0] grant1, grant0;
  logic       busy1, busy0, r1, g1, b1, r0, g0, b0;
  logic [7:0] v1, v0;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  always #5 clk = ~clk;

  rgb_led_arbiter #(.CLK_HZ(HZ), .NUM_REQ(NR), .MIN_HOLD_MS(HOLD), .BLINK_HALF_MS(BH)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .color(color), .blink(blink),
    .grant(grant1), .busy(busy1), .LED_R(r1), .LED_G(g1), .LED_B(b1)
  );

  rgb_led_arbiter #(.CLK_HZ(HZ), .NUM_REQ(NR), .MIN_HOLD_MS(0), .BLINK_HALF_MS(BH)) u_dut_nohold (
    .clk(clk), .rst_n(rst_n), .req(req), .color(color), .blink(blink),
    .grant(grant0), .busy(busy0), .LED_R(r0), .LED_G(g0), .LED_B(b0)
  );

  assign v1 = {grant1, busy1, r1, g1, b1};
  assign v0 = {grant0, busy0, r0, g0, b0};

  // Model: who owns the LED, what it latched, and how many ms ticks have passed since its grant.
  typedef struct {
    int         owner;
    int         ticks;
    logic [2:0] col;
    logic       blk;
  } mst_t;

  mst_t m1, m0;

  function automatic mst_t m_grant(input int w);
    mst_t n;
    n.owner = w;
    n.ticks = 0;
    n.col   = color[3*w +: 3];
    n.blk   = blink[w];
    return n;
  endfunction

  function automatic mst_t m_next(input mst_t s, input int hold, input bit tick);
    mst_t n = s;
    int win = -1;
    for (int i = NR - 1; i >= 0; i--) if (req[i]) win = i;
    if (s.owner < 0) begin
      if (win >= 0) n = m_grant(win);
    end else if (s.ticks < hold || win == s.owner) begin
      if (tick) n.ticks = s.ticks + 1;
    end else if (win >= 0) begin
      n = m_grant(win);
    end else begin
      n.owner = -1;
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_of(input mst_t s);
    logic       on;
    logic       ph;
    logic [3:0] g;
    on = (s.owner >= 0);
    ph = !s.blk || (((s.ticks / BH) % 2) == 0);
    g  = on ? 4'(1 << s.owner) : 4'b0000;
    return {g, on, ~({3{on & ph}} & s.col)};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t edge %0d: got grant/busy/RGB=%b, expected %b", nm, $time, edges, act, exp);
    end
  endtask

  task automatic to_edge(input int k);
    while (edges < k) @(negedge clk);
  endtask

  initial begin
    m1 = '{-1, 0, 3'b000, 1'b0};
    m0 = '{-1, 0, 3'b000, 1'b0};
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m1    = '{-1, 0, 3'b000, 1'b0};
        m0    = '{-1, 0, 3'b000, 1'b0};
        edges = 0;
      end else begin
        edges++;
        m1 = m_next(m1, HOLD, (edges % DIV) == 0);
        m0 = m_next(m0, 0,    (edges % DIV) == 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_hold3", v1, exp_of(m1));
      chk("model_hold0", v0, exp_of(m0));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_hold3", v1, 8'b0000_0_111);
    chk("reset_hold0", v0, 8'b0000_0_111);
    rst_n = 1'b1;

    // single steady green source, req dropped after 5 cycles
    to_edge(2);  req = 4'b0001; color[2:0] = 3'b010;
    to_edge(3);  chk("steady_grant", v1, 8'b0001_1_101);
    to_edge(7);  req = 4'b0000;
    to_edge(30); chk("steady_hold_end", v1, 8'b0001_1_101);
    to_edge(31); chk("steady_idle", v1, 8'b0000_0_111);

    // priority: 1 and 3 together
    to_edge(32); req = 4'b1010; color[5:3] = 3'b011; color[11:9] = 3'b100;
    to_edge(33); chk("prio_grant1", v1, 8'b0010_1_100);
    to_edge(65); chk("prio_keep1", v1, 8'b0010_1_100); req[1] = 1'b0;
    to_edge(66); chk("prio_regrant3", v1, 8'b1000_1_011);

    // hold vs preemption by index 0 one tick into the grant
    to_edge(70); req[0] = 1'b1; color[2:0] = 3'b111;
    to_edge(80); chk("preempt_hold_a", v1, 8'b1000_1_011);
    to_edge(90); chk("preempt_hold_b", v1, 8'b1000_1_011);
    to_edge(91); chk("preempt_grant0", v1, 8'b0001_1_000); req = 4'b0000;
    to_edge(121); chk("preempt_idle", v1, 8'b0000_0_111);

    // blink on red; owner's colour/blink edits mid-grant are ignored
    to_edge(124); req = 4'b0010; color[5:3] = 3'b100; blink = 4'b0010;
    to_edge(125); chk("blink_on", v1, 8'b0010_1_011);
    to_edge(139); chk("blink_pre_toggle", v1, 8'b0010_1_011);
    to_edge(140); chk("blink_off", v1, 8'b0010_1_111);
    to_edge(141); color[5:3] = 3'b010; blink[1] = 1'b0;
    to_edge(159); chk("blink_still_off", v1, 8'b0010_1_111);
    to_edge(160); chk("blink_on_again", v1, 8'b0010_1_011);
    to_edge(165); chk("pre_reset_show", v1, 8'b0010_1_011);

    // async reset in the middle of SHOW
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_hold3", v1, 8'b0000_0_111);
    chk("async_reset_hold0", v0, 8'b0000_0_111);
    req = '0; color = '0; blink = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // zero-hold release and a grant landing on a tick edge
    to_edge(3);  req = 4'b0001; color[2:0] = 3'b001;
    to_edge(4);  chk("nohold_grant", v0, 8'b0001_1_110); req = 4'b0000;
    to_edge(5);  chk("nohold_idle", v0, 8'b0000_0_111);
                 chk("hold3_retained", v1, 8'b0001_1_110);
    to_edge(9);  req = 4'b0100; color[8:6] = 3'b110; blink = 4'b0100;
    to_edge(10); chk("tick_on_load", v0, 8'b0100_1_001);
    to_edge(29); chk("tick_on_load_on", v0, 8'b0100_1_001);
    to_edge(30); chk("tick_on_load_toggle", v0, 8'b0100_1_111);
    to_edge(31); chk("hold3_regrant2", v1, 8'b0100_1_001);
    to_edge(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
